// File: rtl/logic_unit_arbiter_if.sv
// rtl/logic_unit_arbiter_if.sv - request/result bundle for the shared logic unit
//
// Purpose: groups both requester channels and the result channel of
// logic_unit_arbiter into one interface.
// Ports (signals):
//   req0_valid/req0_ready/req0_op/req0_a/req0_b  requester 0 channel
//   req1_valid/req1_ready/req1_op/req1_a/req1_b  requester 1 channel
//   res_valid/res_ready/res_data/res_id/res_err  result channel
// Modports:
//   slave  - the arbiter (consumes requests, produces results)
//   master - the environment (requesters plus result consumer)

interface logic_unit_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id, res_err
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id, res_err
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin shared AND/OR/XOR unit with one-deep result register
//
// Purpose: two requesters share one bitwise logic unit. A round-robin
// pointer picks one request per cycle, the selected operation is computed
// combinationally and captured into a one-deep result register that is
// drained through a valid/ready handshake. Drain and refill may happen on
// the same edge, giving one operation per cycle when the consumer never
// stalls.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous reset, active low
//   bus    - logic_unit_arbiter_if.slave: both request channels and the
//            result channel (res_data/res_id/res_err qualified by res_valid)
// Opcodes: 00 AND, 01 OR, 10 XOR, 11 reserved (result 0, res_err = 1).

module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    logic_unit_arbiter_if.slave bus
);
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } outState_t;

    outState_t        state;
    outState_t        stateNext;

    logic             lastGrant;
    logic             anyValid;
    logic             selIdx;
    logic             canAccept;
    logic             accept;

    logic [1:0]       selOp;
    logic [WIDTH-1:0] selA;
    logic [WIDTH-1:0] selB;
    logic [WIDTH-1:0] aluResult;
    logic             aluErr;

    logic [WIDTH-1:0] resData;
    logic             resId;
    logic             resErr;

    // Round-robin pick: a lone request always wins; with both pending the
    // requester that was not granted last wins. selIdx is don't-care when
    // nothing is pending because accept is then low.
    always_comb begin
        anyValid = bus.req0_valid || bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            selIdx = ~lastGrant;
        end else begin
            selIdx = bus.req1_valid;
        end
    end

    // Operand steering and the shared logic unit.
    always_comb begin
        selOp     = selIdx ? bus.req1_op : bus.req0_op;
        selA      = selIdx ? bus.req1_a  : bus.req0_a;
        selB      = selIdx ? bus.req1_b  : bus.req0_b;
        aluErr    = 1'b0;
        aluResult = '0;
        case (selOp)
            OP_AND:  aluResult = selA & selB;
            OP_OR:   aluResult = selA | selB;
            OP_XOR:  aluResult = selA ^ selB;
            default: begin
                aluResult = '0;
                aluErr    = 1'b1;
            end
        endcase
    end

    // Output register FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Output register FSM: next state. A FULL register that is drained and
    // refilled on the same edge stays FULL.
    always_comb begin
        stateNext = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    stateNext = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    stateNext = FULL;
                end else if (bus.res_ready) begin
                    stateNext = EMPTY;
                end
            end
            default: stateNext = EMPTY;
        endcase
    end

    // Output register FSM: outputs. rst_n gates the readies so no request
    // reports acceptance while the block is held in reset.
    always_comb begin
        canAccept      = rst_n && ((state == EMPTY) || bus.res_ready);
        accept         = canAccept && anyValid;
        bus.req0_ready = accept && !selIdx;
        bus.req1_ready = accept && selIdx;
        bus.res_valid  = (state == FULL);
    end

    // Result payload and priority pointer. Both move only on an accept, so
    // a stalled consumer freezes res_* and does not rotate priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resData   <= '0;
            resId     <= 1'b0;
            resErr    <= 1'b0;
            lastGrant <= 1'b1;
        end else if (accept) begin
            resData   <= aluResult;
            resId     <= selIdx;
            resErr    <= aluErr;
            lastGrant <= selIdx;
        end
    end

    assign bus.res_data = resData;
    assign bus.res_id   = resId;
    assign bus.res_err  = resErr;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - scoreboard bench for logic_unit_arbiter

module tb_logic_unit_arbiter;
    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } expRes_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    expRes_t expQ[$];

    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.WIDTH(32)) bus ();

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic id, input logic [31:0] data, input logic err);
        expRes_t e;
        e.id   = id;
        e.data = data;
        e.err  = err;
        expQ.push_back(e);
    endtask

    task automatic setReq0(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req0_valid = v;
        bus.req0_op    = op;
        bus.req0_a     = a;
        bus.req0_b     = b;
    endtask

    task automatic setReq1(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req1_valid = v;
        bus.req1_op    = op;
        bus.req1_a     = a;
        bus.req1_b     = b;
    endtask

    // Check readies mid-cycle, then advance to just after the next rising edge.
    task automatic step(input logic e0, input logic e1, input string name);
        @(negedge clk);
        chk({name, " req0_ready"}, {31'b0, bus.req0_ready}, {31'b0, e0});
        chk({name, " req1_ready"}, {31'b0, bus.req1_ready}, {31'b0, e1});
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every output transfer pops one expected result.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got id=%0d data=%h err=%0d expected none",
                         bus.res_id, bus.res_data, bus.res_err);
            end else begin
                expRes_t e;
                e = expQ.pop_front();
                chk("mon res_id", {31'b0, bus.res_id}, {31'b0, e.id});
                chk("mon res_data", bus.res_data, e.data);
                chk("mon res_err", {31'b0, bus.res_err}, {31'b0, e.err});
            end
        end
    end

    logic [31:0] soloExp [4];

    initial begin
        soloExp[0] = 32'h00000101;
        soloExp[1] = 32'h00000102;
        soloExp[2] = 32'h00000103;
        soloExp[3] = 32'h00000104;

        // Reset: readies must stay low even with both requests pending.
        setReq0(1'b1, 2'b00, 32'h0, 32'h0);
        setReq1(1'b1, 2'b00, 32'h0, 32'h0);
        bus.res_ready = 1'b1;
        #12;
        chk("rst req0_ready", {31'b0, bus.req0_ready}, 32'h0);
        chk("rst req1_ready", {31'b0, bus.req1_ready}, 32'h0);
        chk("rst res_valid", {31'b0, bus.res_valid}, 32'h0);
        chk("rst res_data", bus.res_data, 32'h0);
        chk("rst res_id", {31'b0, bus.res_id}, 32'h0);
        chk("rst res_err", {31'b0, bus.res_err}, 32'h0);
        setReq0(1'b0, 2'b00, 32'h0, 32'h0);
        setReq1(1'b0, 2'b00, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single AND from requester 0, one-cycle latency.
        setReq0(1'b1, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00);
        pushExp(1'b0, 32'hF000F000, 1'b0);
        step(1'b1, 1'b0, "t1 accept");
        chk("t1 res_valid", {31'b0, bus.res_valid}, 32'h1);
        chk("t1 res_data", bus.res_data, 32'hF000F000);
        setReq0(1'b0, 2'b00, 32'h0, 32'h0);
        step(1'b0, 1'b0, "t1 idle");

        // Alternating grants under continuous contention.
        applyReset();
        setReq0(1'b1, 2'b01, 32'h0000FFFF, 32'h00FF0000);
        setReq1(1'b1, 2'b10, 32'h12345678, 32'hFFFFFFFF);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pushExp(1'b0, 32'h00FFFFFF, 1'b0);
            step(1'b1, 1'b0, "t2 grant0");
            pushExp(1'b1, 32'hEDCBA987, 1'b0);
            step(1'b0, 1'b1, "t2 grant1");
        end

        // Stall: readies low, result frozen, priority not rotated.
        pushExp(1'b0, 32'h00FFFFFF, 1'b0);
        step(1'b1, 1'b0, "t3 grant0");
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, "t3 stall");
            chk("t3 hold res_valid", {31'b0, bus.res_valid}, 32'h1);
            chk("t3 hold res_data", bus.res_data, 32'h00FFFFFF);
            chk("t3 hold res_id", {31'b0, bus.res_id}, 32'h0);
        end
        bus.res_ready = 1'b1;
        pushExp(1'b1, 32'hEDCBA987, 1'b0);
        step(1'b0, 1'b1, "t3 drain_refill");
        setReq0(1'b0, 2'b00, 32'h0, 32'h0);
        setReq1(1'b0, 2'b00, 32'h0, 32'h0);
        step(1'b0, 1'b0, "t3 idle");

        // Reserved opcode, then a normal op clears res_err.
        setReq1(1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        pushExp(1'b1, 32'h00000000, 1'b1);
        step(1'b0, 1'b1, "t4 reserved");
        chk("t4 res_err", {31'b0, bus.res_err}, 32'h1);
        setReq1(1'b1, 2'b00, 32'hFFFFFFFF, 32'h0000FFFF);
        pushExp(1'b1, 32'h0000FFFF, 1'b0);
        step(1'b0, 1'b1, "t4 and");
        chk("t4 res_err cleared", {31'b0, bus.res_err}, 32'h0);
        setReq1(1'b0, 2'b00, 32'h0, 32'h0);
        step(1'b0, 1'b0, "t4 idle");

        // Asynchronous reset while a result is held undrained.
        bus.res_ready = 1'b0;
        setReq0(1'b1, 2'b01, 32'h0F0F0F0F, 32'hF0F0F0F0);
        step(1'b1, 1'b0, "t5 fill");
        chk("t5 full res_data", bus.res_data, 32'hFFFFFFFF);
        setReq1(1'b1, 2'b10, 32'h00000000, 32'h13579BDF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 async res_valid", {31'b0, bus.res_valid}, 32'h0);
        chk("t5 async res_data", bus.res_data, 32'h0);
        chk("t5 async req0_ready", {31'b0, bus.req0_ready}, 32'h0);
        chk("t5 async req1_ready", {31'b0, bus.req1_ready}, 32'h0);
        setReq0(1'b1, 2'b00, 32'hAAAA5555, 32'hFFFF0000);
        bus.res_ready = 1'b1;
        expQ.delete();
        pushExp(1'b0, 32'hAAAA0000, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("t5 post req0_ready", {31'b0, bus.req0_ready}, 32'h1);
        chk("t5 post req1_ready", {31'b0, bus.req1_ready}, 32'h0);
        @(posedge clk);
        #1;

        // Requester 1 alone, then contention hands the next grant to 0.
        setReq0(1'b0, 2'b00, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            setReq1(1'b1, 2'b01, 32'(i + 1), 32'h00000100);
            pushExp(1'b1, soloExp[i], 1'b0);
            step(1'b0, 1'b1, "t6 solo1");
        end
        setReq0(1'b1, 2'b10, 32'hFFFF0000, 32'h0F0F0F0F);
        pushExp(1'b0, 32'hF0F00F0F, 1'b0);
        step(1'b1, 1'b0, "t6 both0");
        pushExp(1'b1, 32'h00000104, 1'b0);
        step(1'b0, 1'b1, "t6 both1");
        pushExp(1'b0, 32'hF0F00F0F, 1'b0);
        step(1'b1, 1'b0, "t6 both0b");
        setReq0(1'b0, 2'b00, 32'h0, 32'h0);
        setReq1(1'b0, 2'b00, 32'h0, 32'h0);
        step(1'b0, 1'b0, "t6 idle");
        step(1'b0, 1'b0, "t6 idle2");

        chk("scoreboard empty", 32'(expQ.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
